// File: rtl/picosoc_min.sv
// Minimal SoC: compact RV32I core (picorv32 native bus), word-addressed RAM and a 10-bit LED register.
// Every bus access is acknowledged one cycle after it is seen, whatever the address.

module picorv32 #(
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
  parameter logic [31:0] STACKADDR      = 32'hffff_ffff
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        trap,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {S_INIT, S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;

  state_t      state, state_next;
  logic [31:0] pc, instr, maddr;
  logic [31:0] regs [0:31];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] a, b;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign a      = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign b      = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  logic [31:0] op_b, alu, ex_wdata, ex_pc_next, ex_addr;
  logic        take, ex_legal, ex_mem, ex_we;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    op_b = (opcode == OP_REG) ? b : imm_i;
    case (funct3)
      3'd0:    alu = (opcode == OP_REG && instr[30]) ? a - op_b : a + op_b;
      3'd1:    alu = a << op_b[4:0];
      3'd2:    alu = {31'b0, $signed(a) < $signed(op_b)};
      3'd3:    alu = {31'b0, a < op_b};
      3'd4:    alu = a ^ op_b;
      3'd5:    alu = instr[30] ? $unsigned($signed(a) >>> op_b[4:0]) : a >> op_b[4:0];
      3'd6:    alu = a | op_b;
      default: alu = a & op_b;
    endcase
    case (funct3)
      3'd0:    take = (a == b);
      3'd1:    take = (a != b);
      3'd4:    take = ($signed(a) < $signed(b));
      3'd5:    take = ($signed(a) >= $signed(b));
      3'd6:    take = (a < b);
      3'd7:    take = (a >= b);
      default: take = 1'b0;
    endcase
    ex_legal   = 1'b1;
    ex_mem     = 1'b0;
    ex_we      = 1'b0;
    ex_wdata   = alu;
    ex_pc_next = pc + 32'd4;
    ex_addr    = a + imm_i;
    case (opcode)
      OP_LUI:    begin ex_we = 1'b1; ex_wdata = imm_u; end
      OP_AUIPC:  begin ex_we = 1'b1; ex_wdata = pc + imm_u; end
      OP_JAL:    begin ex_we = 1'b1; ex_wdata = pc + 32'd4; ex_pc_next = pc + imm_j; end
      OP_JALR:   begin ex_we = 1'b1; ex_wdata = pc + 32'd4; ex_pc_next = (a + imm_i) & ~32'd1; end
      OP_BRANCH: begin
        ex_legal = !(funct3 inside {3'd2, 3'd3});
        if (take) ex_pc_next = pc + imm_b;
      end
      OP_LOAD:   begin ex_mem = 1'b1; ex_legal = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
      OP_STORE:  begin ex_mem = 1'b1; ex_addr = a + imm_s; ex_legal = funct3 inside {3'd0, 3'd1, 3'd2}; end
      OP_IMM, OP_REG: ex_we = 1'b1;
      OP_FENCE:  ;
      default:   ex_legal = 1'b0;
    endcase
  end

  logic [31:0] ld_shift, ld_data, st_wdata;
  logic [3:0]  st_wstrb;

  always_comb begin
    ld_shift = mem_rdata >> {maddr[1:0], 3'b000};
    case (funct3)
      3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'd1:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'd4:    ld_data = {24'b0, ld_shift[7:0]};
      3'd5:    ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
    case (funct3[1:0])
      2'd0:    begin st_wdata = {4{b[7:0]}};  st_wstrb = 4'b0001 << maddr[1:0]; end
      2'd1:    begin st_wdata = {2{b[15:0]}}; st_wstrb = maddr[1] ? 4'b1100 : 4'b0011; end
      default: begin st_wdata = b;            st_wstrb = 4'b1111; end
    endcase
  end

  // Register file write port; INIT seeds the stack pointer once after reset.
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = ex_wdata;
    case (state)
      S_INIT: begin rf_we = 1'b1; rf_waddr = 5'd2; rf_wdata = STACKADDR; end
      S_EXEC: rf_we = ex_legal && ex_we && (rd != 5'd0);
      S_MEM:  begin rf_we = mem_ready && (opcode == OP_LOAD) && (rd != 5'd0); rf_wdata = ld_data; end
      default: ;
    endcase
  end

  // NOTE: storage arrays carry no reset, so they stay plain RAM rather than a wall of reset flops.
  always_ff @(posedge clk) begin
    if (rf_we) regs[rf_waddr] <= rf_wdata;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_INIT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  state_next = S_FETCH;
      S_FETCH: if (mem_ready) state_next = S_EXEC;
      S_EXEC:  state_next = !ex_legal ? S_TRAP : (ex_mem ? S_MEM : S_FETCH);
      S_MEM:   if (mem_ready) state_next = S_FETCH;
      default: state_next = S_TRAP;
    endcase
  end

  always_comb begin
    mem_valid = (state == S_FETCH) || (state == S_MEM);
    mem_instr = (state == S_FETCH);
    mem_addr  = (state == S_FETCH) ? pc : {maddr[31:2], 2'b00};
    mem_wdata = 32'd0;
    mem_wstrb = 4'b0000;
    if (state == S_MEM && opcode == OP_STORE) begin
      mem_wdata = st_wdata;
      mem_wstrb = st_wstrb;
    end
    trap = (state == S_TRAP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc    <= PROGADDR_RESET;
      instr <= 32'd0;
      maddr <= 32'd0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) instr <= mem_rdata;
        S_EXEC:  if (ex_legal) begin
          if (ex_mem) maddr <= ex_addr;
          else        pc    <= ex_pc_next;
        end
        S_MEM:   if (mem_ready) pc <= pc + 32'd4;
        default: ;
      endcase
    end
  end
endmodule

module picosoc_min_ram #(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               wstrb,
  input  logic [$clog2(WORDS)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  reg [31:0] mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[idx];
  end
endmodule

module picosoc_min #(
  parameter int          MEM_WORDS  = 1024,
  parameter logic [31:0] LED_ADDR   = 32'h1000_0000,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] STACK_ADDR = 32'(MEM_WORDS * 4)
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [9:0] ledr
);
  localparam int AW = $clog2(MEM_WORDS);

  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, ram_rdata;
  logic [3:0]  mem_wstrb;
  logic        ram_sel, led_sel, ram_sel_q, led_sel_q, access;
  logic [1:0]  rst_sync;
  logic [9:0]  led;

  // Core reset is set asynchronously and released two clocks after resetn falls.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) rst_sync <= 2'b11;
    else        rst_sync <= {rst_sync[0], 1'b0};
  end

  picorv32 #(
    .PROGADDR_RESET (RESET_PC),
    .STACKADDR      (STACK_ADDR)
  ) core (
    .clk       (clk),
    .resetn    (~rst_sync[1]),
    .trap      (),
    .mem_valid (mem_valid),
    .mem_instr (),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  assign ram_sel = mem_addr < 32'(MEM_WORDS * 4);
  assign led_sel = mem_addr[31:2] == LED_ADDR[31:2];
  assign access  = mem_valid && !mem_ready;

  picosoc_min_ram #(.WORDS(MEM_WORDS)) memory (
    .clk   (clk),
    .we    (access && ram_sel),
    .wstrb (mem_wstrb),
    .idx   (mem_addr[AW+1:2]),
    .wdata (mem_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      mem_ready <= 1'b0;
      ram_sel_q <= 1'b0;
      led_sel_q <= 1'b0;
      led       <= 10'd0;
    end else begin
      mem_ready <= access;
      if (access) begin
        ram_sel_q <= ram_sel;
        led_sel_q <= led_sel;
        if (led_sel && mem_wstrb[0]) led[7:0] <= mem_wdata[7:0];
        if (led_sel && mem_wstrb[1]) led[9:8] <= mem_wdata[9:8];
      end
    end
  end

  // Unmapped addresses read as zero but are still acknowledged.
  assign mem_rdata = ram_sel_q ? ram_rdata : (led_sel_q ? {22'b0, led} : 32'd0);
  assign ledr      = led;
endmodule

// File: tb/tb_picosoc_min.sv
// Bench for picosoc_min: preloads small RV32I programs and scoreboards LED and RAM results.
module tb_picosoc_min;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] ledr;

  always #5 clk = ~clk;

  picosoc_min dut (
    .clk    (clk),
    .resetn (resetn),
    .ledr   (ledr)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef enum {CHK_LED, CHK_MEM} chk_kind_t;
  typedef struct {
    chk_kind_t   kind;
    int          idx;
    logic [31:0] value;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];

  task automatic expect_led(input string name, input logic [9:0] v);
    exp_t e;
    e.kind = CHK_LED; e.idx = 0; e.value = {22'b0, v}; e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_mem(input string name, input int idx, input logic [31:0] v);
    exp_t e;
    e.kind = CHK_MEM; e.idx = idx; e.value = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain_scoreboard();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = (e.kind == CHK_LED) ? {22'b0, ledr} : dut.memory.mem[e.idx];
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", e.name, got, e.value);
      end
    end
  endtask

  task automatic load_program();
    for (int i = 0; i < 128; i++) dut.memory.mem[i] = 32'd0;
    for (int i = 0; i < prog.size(); i++) dut.memory.mem[i] = prog[i];
  endtask

  task automatic enter_reset();
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    prog = '{32'h100000B7, 32'h00000113, 32'h00110113, 32'h0020A023, 32'h0000006F};
    load_program();
    repeat (100) @(negedge clk);
    vectors++;
    if (ledr !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_led: got %h, expected %h", ledr, 10'd0);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (dut.memory.mem[i] !== prog[i]) begin
        miscompares++;
        $display("FAIL reset_mem[%0d]: got %h, expected %h", i, dut.memory.mem[i], prog[i]);
      end
    end
  endtask

  task automatic test_led_program();
    expect_led("led_after_sw", 10'b0000000001);
    for (int i = 0; i < 5; i++) expect_mem($sformatf("prog_mem[%0d]", i), i, prog[i]);
    release_reset();
    repeat (1000) @(negedge clk);
    drain_scoreboard();
  endtask

  task automatic test_mid_run_reset();
    @(negedge clk);
    #2 resetn = 1'b1;
    #1;
    vectors++;
    if (ledr !== 10'd0) begin
      miscompares++;
      $display("FAIL midrun_led_clear: got %h, expected %h", ledr, 10'd0);
    end
    for (int i = 0; i < 5; i++) expect_mem($sformatf("midrun_mem[%0d]", i), i, prog[i]);
    repeat (20) @(negedge clk);
    drain_scoreboard();
    expect_led("led_after_rerun", 10'd1);
    release_reset();
    repeat (300) @(negedge clk);
    drain_scoreboard();
  endtask

  task automatic test_led_lanes();
    int n;
    enter_reset();
    prog = '{32'h100000B7, 32'hFFF00113, 32'h0020A023, 32'h00008023, 32'h0000006F};
    load_program();
    release_reset();
    n = 0;
    while (ledr !== 10'h3FF && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (ledr !== 10'h3FF) begin
      miscompares++;
      $display("FAIL led_sw_ones: got %h, expected %h after %0d cycles", ledr, 10'h3FF, n);
    end
    expect_led("led_sb_lane0", 10'h300);
    repeat (200) @(negedge clk);
    drain_scoreboard();
  endtask

  task automatic test_ram_rw();
    enter_reset();
    prog = '{32'h100000B7, 32'h123451B7, 32'h2A518193, 32'h10302023, 32'h10002203,
             32'h0040A023, 32'h7CD00293, 32'h10501123, 32'h0000006F};
    load_program();
    dut.memory.mem[64] = 32'hDEADBEEF;
    dut.memory.mem[63] = 32'h01234567;
    expect_mem("ram_word64", 64, 32'h07CD52A5);
    expect_mem("ram_word63", 63, 32'h01234567);
    expect_led("led_from_lw", 10'h2A5);
    release_reset();
    repeat (400) @(negedge clk);
    drain_scoreboard();
  endtask

  task automatic test_unmapped();
    enter_reset();
    prog = '{32'h100000B7, 32'h20000337, 32'h00032383, 32'h10702223,
             32'h00500113, 32'h0020A023, 32'h0000006F};
    load_program();
    dut.memory.mem[65] = 32'hCAFEF00D;
    expect_mem("unmapped_read_zero", 65, 32'h00000000);
    expect_led("led_after_unmapped", 10'h005);
    release_reset();
    repeat (400) @(negedge clk);
    drain_scoreboard();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_led_program();
    test_mid_run_reset();
    test_led_lanes();
    test_ram_rw();
    test_unmapped();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
